// File: rtl/output_tile_buffer.sv
// ============================================================================
// output_tile_buffer
// ----------------------------------------------------------------------------
// Banked result buffer for the PE array. Each entry holds BANKS banks of
// LANES words of DW bits; word index b*LANES+l maps to bank b, lane l.
//
// Two write modes share one memory write port:
//   mode = 0 : vector beat, a whole entry written at wr_addr in one cycle
//              (accepted only while no scalar assembly is in progress).
//   mode = 1 : scalar beat, one word per bank. LANES beats are gathered
//              lane by lane in an assembly register; the first beat fixes
//              the target address. After the last lane the entry is
//              committed to memory in a single COMMIT cycle.
//
// Each entry has a valid bit; occupancy is the population count of the valid
// bits. clear invalidates every entry; a write committing in the same cycle
// keeps its own entry valid. Reads have one cycle of latency and return zero
// data for entries that are not valid.
//
// Build option:
//   OUTPUT_TILE_BUFFER_BYPASS_EN - when defined, a read of the address being
//   written in the same cycle returns the new data with rd_hit = 1. When not
//   defined, the read returns the contents and valid bit from before the write.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   mode       in   0 = vector write, 1 = scalar write
//   wr_valid   in   write beat offered
//   wr_ready   out  write beat accepted when wr_valid & wr_ready
//   wr_addr    in   target entry (vector beats, first scalar beat)
//   wr_vec     in   vector payload, BANKS*LANES words
//   wr_scalar  in   scalar payload, one word per bank
//   flush      in   abandon the partial scalar assembly
//   clear      in   invalidate all entries
//   rd_en      in   read request
//   rd_addr    in   read entry
//   rd_valid   out  rd_data valid (one cycle after rd_en)
//   rd_hit     out  read entry held valid data
//   rd_data    out  read payload, same layout as wr_vec
//   occupancy  out  number of valid entries
// ============================================================================
module output_tile_buffer #(
  parameter int DW    = 32,
  parameter int BANKS = 4,
  parameter int LANES = 16,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int VW   = BANKS * LANES * DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [VW-1:0]         wr_vec,
  input  logic [BANKS*DW-1:0]   wr_scalar,
  input  logic                  flush,
  input  logic                  clear,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic                  rd_valid,
  output logic                  rd_hit,
  output logic [VW-1:0]         rd_data,
  output logic [AW:0]           occupancy
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [LW-1:0]   lane_cnt;
  logic [LW-1:0]   lane_cnt_next;
  logic [AW-1:0]   lat_addr;
  logic [AW-1:0]   lat_addr_next;
  logic [LW-1:0]   scl_lane;
  logic            vec_acc;
  logic            scl_acc;

  logic [VW-1:0]   asm_data;
  logic [VW-1:0]   mem [DEPTH];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [VW-1:0]   mem_wdata;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_next;
  logic [AW:0]      occ_next;

  logic            rd_hit_next;
  logic [VW-1:0]   rd_word;
  logic [VW-1:0]   rd_data_next;

  // Number of set bits in the valid vector.
  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + {{AW{1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Write-side FSM: next state, lane counter, latched address, handshake.
  always_comb begin
    state_next    = state;
    lane_cnt_next = lane_cnt;
    lat_addr_next = lat_addr;
    scl_lane      = lane_cnt;
    wr_ready      = 1'b1;
    vec_acc       = 1'b0;
    scl_acc       = 1'b0;
    case (state)
      IDLE: begin
        scl_lane = '0;
        if (wr_valid && !mode) begin
          vec_acc = 1'b1;
        end else if (wr_valid && mode && !flush) begin
          // First scalar beat: fixes the destination and fills lane 0.
          scl_acc       = 1'b1;
          lat_addr_next = wr_addr;
          lane_cnt_next = LW'(1);
          state_next    = (LANES == 1) ? COMMIT : FILL;
        end else begin
          state_next = IDLE;
        end
      end
      FILL: begin
        // Vector beats are held off while an assembly is open.
        wr_ready = mode;
        if (flush) begin
          state_next    = IDLE;
          lane_cnt_next = '0;
        end else if (wr_valid && mode) begin
          scl_acc = 1'b1;
          if (lane_cnt == LAST_LANE) begin
            state_next = COMMIT;
          end else begin
            lane_cnt_next = lane_cnt + LW'(1);
          end
        end else begin
          state_next = FILL;
        end
      end
      COMMIT: begin
        // Memory port is busy with the assembled entry; flush has no effect.
        wr_ready      = 1'b0;
        state_next    = IDLE;
        lane_cnt_next = '0;
      end
      default: begin
        state_next    = IDLE;
        lane_cnt_next = '0;
      end
    endcase
  end

  // Select the single memory write: vector beat or committed assembly.
  always_comb begin
    mem_we = vec_acc || (state == COMMIT);
    if (vec_acc) begin
      mem_waddr = wr_addr;
      mem_wdata = wr_vec;
    end else begin
      mem_waddr = lat_addr;
      mem_wdata = asm_data;
    end
  end

  // Valid-bit update: clear first, then the write of this cycle re-validates.
  always_comb begin
    if (clear) begin
      valid_next = '0;
    end else begin
      valid_next = valid;
    end
    if (mem_we) begin
      valid_next[mem_waddr] = 1'b1;
    end else begin
      valid_next[mem_waddr] = valid_next[mem_waddr];
    end
    occ_next = popcount(valid_next);
  end

  // Read lookup, optionally forwarding the write of the same cycle.
  always_comb begin
    rd_hit_next = valid[rd_addr];
    rd_word     = mem[rd_addr];
`ifdef OUTPUT_TILE_BUFFER_BYPASS_EN
    if (mem_we && (mem_waddr == rd_addr)) begin
      rd_hit_next = 1'b1;
      rd_word     = mem_wdata;
    end else begin
      rd_hit_next = valid[rd_addr];
    end
`endif
    if (rd_hit_next) begin
      rd_data_next = rd_word;
    end else begin
      rd_data_next = '0;
    end
  end

  // Control state, valid bits and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lane_cnt  <= '0;
      lat_addr  <= '0;
      valid     <= '0;
      occupancy <= '0;
    end else begin
      state     <= state_next;
      lane_cnt  <= lane_cnt_next;
      lat_addr  <= lat_addr_next;
      valid     <= valid_next;
      occupancy <= occ_next;
    end
  end

  // Registered read outputs; data and hit hold while no read is requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_hit  <= rd_hit_next;
        rd_data <= rd_data_next;
      end
    end
  end

  // Scalar assembly register; stale lanes are harmless since every lane is
  // rewritten before a commit, so no reset is needed.
  always_ff @(posedge clk) begin
    if (scl_acc) begin
      for (int b = 0; b < BANKS; b++) begin
        asm_data[(b * LANES + int'(scl_lane)) * DW +: DW] <= wr_scalar[b * DW +: DW];
      end
    end
  end

  // Entry storage; contents survive reset and are hidden by the valid bits.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_output_tile_buffer.sv
module tb_output_tile_buffer;

  localparam int DW    = 32;
  localparam int BANKS = 4;
  localparam int LANES = 16;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int VW    = BANKS * LANES * DW;
  localparam int NW    = VW / DW;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                mode = 1'b0;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic [AW-1:0]       wr_addr = '0;
  logic [VW-1:0]       wr_vec = '0;
  logic [BANKS*DW-1:0] wr_scalar = '0;
  logic                flush = 1'b0;
  logic                clear = 1'b0;
  logic                rd_en = 1'b0;
  logic [AW-1:0]       rd_addr = '0;
  logic                rd_valid;
  logic                rd_hit;
  logic [VW-1:0]       rd_data;
  logic [AW:0]         occupancy;

  int passed = 0;
  int total  = 0;

  output_tile_buffer #(.DW(DW), .BANKS(BANKS), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_vec(wr_vec), .wr_scalar(wr_scalar), .flush(flush),
    .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_hit(rd_hit), .rd_data(rd_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: entry store, valid flags, and the open scalar transaction
  // tracked as "words collected so far" plus a pending-commit flag.
  logic [VW-1:0] m_mem [DEPTH];
  bit            m_valid [DEPTH];
  int            m_cnt;
  bit            m_commit;
  logic [AW-1:0] m_addr;
  logic [VW-1:0] m_asm;
  bit            e_rd_valid;
  bit            e_rd_hit;
  logic [VW-1:0] e_rd_data;
  logic [AW:0]   e_occ;
  bit            e_ready;
  logic          obs_ready;

  function automatic int dw_idx(input logic [VW-1:0] a, input logic [VW-1:0] b);
    for (int i = 0; i < NW; i++) begin
      if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
    end
    return 0;
  endfunction

  function automatic logic [DW-1:0] wsel(input logic [VW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NW; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_cnt = 0;
    m_commit = 1'b0;
    e_rd_valid = 1'b0;
    e_rd_hit = 1'b0;
    e_rd_data = '0;
    e_occ = '0;
  endtask

  task automatic model_edge();
    bit            wr;
    logic [AW-1:0] a;
    logic [VW-1:0] d;
    int            n;
    e_ready = !m_commit && !(m_cnt > 0 && !mode);
    wr = 1'b0;
    a = '0;
    d = '0;
    if (m_commit) begin
      wr = 1'b1; a = m_addr; d = m_asm;
      m_commit = 1'b0; m_cnt = 0;
    end else begin
      if (wr_valid && e_ready && !mode) begin
        wr = 1'b1; a = wr_addr; d = wr_vec;
      end else if (wr_valid && e_ready && mode && !flush) begin
        if (m_cnt == 0) m_addr = wr_addr;
        for (int b = 0; b < BANKS; b++)
          m_asm[(b*LANES + m_cnt)*DW +: DW] = wr_scalar[b*DW +: DW];
        m_cnt++;
        if (m_cnt == LANES) m_commit = 1'b1;
      end
      if (flush) m_cnt = 0;
    end
    if (rd_en) begin
      e_rd_valid = 1'b1;
      e_rd_hit   = m_valid[rd_addr];
      e_rd_data  = e_rd_hit ? m_mem[rd_addr] : '0;
`ifdef OUTPUT_TILE_BUFFER_BYPASS_EN
      if (wr && a == rd_addr) begin
        e_rd_hit  = 1'b1;
        e_rd_data = d;
      end
`endif
    end else begin
      e_rd_valid = 1'b0;
    end
    if (clear) for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    if (wr) begin
      m_mem[a] = d;
      m_valid[a] = 1'b1;
    end
    n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
    e_occ = (AW+1)'(n);
  endtask

  // One clock: sample wr_ready for the driven inputs, step the model at the
  // edge, then leave time 1 unit past the edge for output sampling.
  task automatic cycle();
    #1 obs_ready = wr_ready;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; flush = 1'b0; clear = 1'b0; rd_en = 1'b0; mode = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #10;
    model_reset();
    total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else passed++;
    total++; if (rd_hit !== 1'b0) $display("FAIL reset_rd_hit got %b want 0", rd_hit); else passed++;
    total++; if (rd_data !== '0) $display("FAIL reset_rd_data word %0d got %h want 0", dw_idx(rd_data, '0), wsel(rd_data, dw_idx(rd_data, '0))); else passed++;
    total++; if (occupancy !== '0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", wr_ready); else passed++;
    idle_inputs();
    cycle();
  endtask

  task automatic test_vector();
    logic [VW-1:0] exp;
    for (int i = 0; i < NW; i++) exp[i*DW +: DW] = DW'(i);
    idle_inputs();
    wr_valid = 1'b1; wr_addr = AW'(5); wr_vec = exp;
    cycle();
    total++; if (obs_ready !== 1'b1) $display("FAIL vec_ready got %b want 1", obs_ready); else passed++;
    idle_inputs();
    rd_en = 1'b1; rd_addr = AW'(5);
    cycle();
    idle_inputs();
    total++; if (rd_valid !== 1'b1) $display("FAIL vec_rd_valid got %b want 1", rd_valid); else passed++;
    total++; if (rd_hit !== 1'b1) $display("FAIL vec_rd_hit got %b want 1", rd_hit); else passed++;
    total++; if (rd_data !== exp) $display("FAIL vec_rd_data word %0d got %h want %h", dw_idx(rd_data, exp), wsel(rd_data, dw_idx(rd_data, exp)), wsel(exp, dw_idx(rd_data, exp))); else passed++;
    total++; if (occupancy !== 6'd1) $display("FAIL vec_occupancy got %0d want 1", occupancy); else passed++;
    cycle();
    total++; if (rd_valid !== 1'b0) $display("FAIL hold_rd_valid got %b want 0", rd_valid); else passed++;
    total++; if (rd_data !== exp) $display("FAIL hold_rd_data word %0d got %h want %h", dw_idx(rd_data, exp), wsel(rd_data, dw_idx(rd_data, exp)), wsel(exp, dw_idx(rd_data, exp))); else passed++;
  endtask

  task automatic test_scalar();
    logic [VW-1:0] exp;
    for (int k = 0; k < LANES; k++) begin
      idle_inputs();
      mode = 1'b1; wr_valid = 1'b1;
      wr_addr = (k == 0) ? AW'(3) : AW'($urandom_range(8, 31));
      for (int b = 0; b < BANKS; b++) begin
        wr_scalar[b*DW +: DW] = DW'(100*b + k);
        exp[(b*LANES + k)*DW +: DW] = DW'(100*b + k);
      end
      cycle();
      total++; if (obs_ready !== 1'b1) $display("FAIL scalar_ready beat %0d got %b want 1", k, obs_ready); else passed++;
    end
    // Commit cycle: a further scalar beat is offered and must be refused.
    wr_scalar = '1;
    cycle();
    total++; if (obs_ready !== 1'b0) $display("FAIL commit_ready got %b want 0", obs_ready); else passed++;
    idle_inputs();
    rd_en = 1'b1; rd_addr = AW'(3);
    cycle();
    idle_inputs();
    total++; if (rd_hit !== 1'b1) $display("FAIL scalar_rd_hit got %b want 1", rd_hit); else passed++;
    total++; if (rd_data !== exp) $display("FAIL scalar_rd_data word %0d got %h want %h", dw_idx(rd_data, exp), wsel(rd_data, dw_idx(rd_data, exp)), wsel(exp, dw_idx(rd_data, exp))); else passed++;
    total++; if (occupancy !== 6'd2) $display("FAIL scalar_occupancy got %0d want 2", occupancy); else passed++;
  endtask

  task automatic test_flush();
    idle_inputs();
    clear = 1'b1;
    cycle();
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      mode = 1'b1; wr_valid = 1'b1; wr_addr = AW'(3);
      wr_scalar = {BANKS{DW'(k + 7)}};
      cycle();
    end
    idle_inputs();
    flush = 1'b1;
    cycle();
    idle_inputs();
    #1;
    total++; if (wr_ready !== 1'b1) $display("FAIL flush_idle_ready got %b want 1", wr_ready); else passed++;
    rd_en = 1'b1; rd_addr = AW'(3);
    cycle();
    idle_inputs();
    total++; if (rd_hit !== 1'b0) $display("FAIL flush_rd_hit got %b want 0", rd_hit); else passed++;
    total++; if (rd_data !== '0) $display("FAIL flush_rd_data word %0d got %h want 0", dw_idx(rd_data, '0), wsel(rd_data, dw_idx(rd_data, '0))); else passed++;
    total++; if (occupancy !== 6'd0) $display("FAIL flush_occupancy got %0d want 0", occupancy); else passed++;
  endtask

  task automatic test_same_cycle();
    logic [VW-1:0] va, vb, vc, exp_d;
    logic          exp_h;
    va = '0; va[DW-1:0] = 32'hA;
    vb = '0; vb[DW-1:0] = 32'hB;
    vc = '0; vc[DW-1:0] = 32'hC;
    idle_inputs();
    wr_valid = 1'b1; wr_addr = AW'(7); wr_vec = va;
    cycle();
    wr_vec = vb; rd_en = 1'b1; rd_addr = AW'(7);
    cycle();
    idle_inputs();
`ifdef OUTPUT_TILE_BUFFER_BYPASS_EN
    exp_d = vb;
`else
    exp_d = va;
`endif
    total++; if (rd_hit !== 1'b1) $display("FAIL rw_valid_rd_hit got %b want 1", rd_hit); else passed++;
    total++; if (rd_data !== exp_d) $display("FAIL rw_valid_rd_data word0 got %h want %h", wsel(rd_data, 0), wsel(exp_d, 0)); else passed++;
    rd_en = 1'b1; rd_addr = AW'(7);
    cycle();
    total++; if (rd_data !== vb) $display("FAIL rw_after_rd_data word0 got %h want %h", wsel(rd_data, 0), wsel(vb, 0)); else passed++;
    // Same-cycle access to an entry that was invalid beforehand.
    idle_inputs();
    clear = 1'b1;
    cycle();
    idle_inputs();
    wr_valid = 1'b1; wr_addr = AW'(7); wr_vec = vc; rd_en = 1'b1; rd_addr = AW'(7);
    cycle();
    idle_inputs();
`ifdef OUTPUT_TILE_BUFFER_BYPASS_EN
    exp_h = 1'b1; exp_d = vc;
`else
    exp_h = 1'b0; exp_d = '0;
`endif
    total++; if (rd_hit !== exp_h) $display("FAIL rw_invalid_rd_hit got %b want %b", rd_hit, exp_h); else passed++;
    total++; if (rd_data !== exp_d) $display("FAIL rw_invalid_rd_data word0 got %h want %h", wsel(rd_data, 0), wsel(exp_d, 0)); else passed++;
  endtask

  task automatic test_clear_full();
    for (int a = 0; a < DEPTH; a++) begin
      idle_inputs();
      wr_valid = 1'b1; wr_addr = AW'(a); wr_vec = rand_vec();
      cycle();
    end
    idle_inputs();
    total++; if (occupancy !== 6'd32) $display("FAIL full_occupancy got %0d want 32", occupancy); else passed++;
    wr_valid = 1'b1; wr_addr = AW'(0); wr_vec = rand_vec();
    cycle();
    idle_inputs();
    total++; if (occupancy !== 6'd32) $display("FAIL overwrite_occupancy got %0d want 32", occupancy); else passed++;
    clear = 1'b1;
    cycle();
    idle_inputs();
    total++; if (occupancy !== 6'd0) $display("FAIL clear_occupancy got %0d want 0", occupancy); else passed++;
    for (int a = 0; a < 3; a++) begin
      wr_valid = 1'b1; wr_addr = AW'(a + 10); wr_vec = rand_vec();
      cycle();
    end
    idle_inputs();
    clear = 1'b1; wr_valid = 1'b1; wr_addr = AW'(4); wr_vec = rand_vec();
    cycle();
    idle_inputs();
    total++; if (occupancy !== 6'd1) $display("FAIL clear_write_occupancy got %0d want 1", occupancy); else passed++;
    rd_en = 1'b1; rd_addr = AW'(4);
    cycle();
    idle_inputs();
    total++; if (rd_hit !== 1'b1) $display("FAIL clear_write_rd_hit got %b want 1", rd_hit); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    logic [VW-1:0] exp;
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      mode = 1'b1; wr_valid = 1'b1; wr_addr = AW'(9); wr_scalar = {BANKS{DW'(32'hDEAD0000 + k)}};
      cycle();
    end
    idle_inputs();
    rst = 1'b0;
    #3 rst = 1'b1;
    model_reset();
    #1;
    total++; if (wr_ready !== 1'b1) $display("FAIL rst_fill_ready got %b want 1", wr_ready); else passed++;
    total++; if (occupancy !== 6'd0) $display("FAIL rst_fill_occupancy got %0d want 0", occupancy); else passed++;
    cycle();
    for (int k = 0; k < LANES; k++) begin
      idle_inputs();
      mode = 1'b1; wr_valid = 1'b1; wr_addr = (k == 0) ? AW'(9) : AW'(1);
      for (int b = 0; b < BANKS; b++) begin
        wr_scalar[b*DW +: DW] = DW'(1000 + 16*b + k);
        exp[(b*LANES + k)*DW +: DW] = DW'(1000 + 16*b + k);
      end
      cycle();
    end
    idle_inputs();
    cycle();
    rd_en = 1'b1; rd_addr = AW'(9);
    cycle();
    idle_inputs();
    total++; if (rd_hit !== 1'b1) $display("FAIL rst_fill_rd_hit got %b want 1", rd_hit); else passed++;
    total++; if (rd_data !== exp) $display("FAIL rst_fill_rd_data word %0d got %h want %h", dw_idx(rd_data, exp), wsel(rd_data, dw_idx(rd_data, exp)), wsel(exp, dw_idx(rd_data, exp))); else passed++;
  endtask

  task automatic test_random();
    int bad;
    for (int c = 0; c < 800; c++) begin
      mode      = (m_cnt > 0) ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
      wr_valid  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      clear     = ($urandom_range(0, 63) == 0);
      rd_en     = 1'($urandom_range(0, 1));
      wr_addr   = AW'($urandom_range(0, 7));
      rd_addr   = AW'($urandom_range(0, 7));
      wr_vec    = rand_vec();
      for (int b = 0; b < BANKS; b++) wr_scalar[b*DW +: DW] = $urandom;
      cycle();
      bad = 0;
      if (obs_ready !== e_ready) begin
        $display("FAIL rand_ready cycle %0d got %b want %b", c, obs_ready, e_ready); bad++;
      end
      if (rd_valid !== e_rd_valid) begin
        $display("FAIL rand_rd_valid cycle %0d got %b want %b", c, rd_valid, e_rd_valid); bad++;
      end
      if (rd_hit !== e_rd_hit) begin
        $display("FAIL rand_rd_hit cycle %0d got %b want %b", c, rd_hit, e_rd_hit); bad++;
      end
      if (rd_data !== e_rd_data) begin
        $display("FAIL rand_rd_data cycle %0d word %0d got %h want %h", c, dw_idx(rd_data, e_rd_data), wsel(rd_data, dw_idx(rd_data, e_rd_data)), wsel(e_rd_data, dw_idx(rd_data, e_rd_data))); bad++;
      end
      if (occupancy !== e_occ) begin
        $display("FAIL rand_occupancy cycle %0d got %0d want %0d", c, occupancy, e_occ); bad++;
      end
      total += 5;
      passed += 5 - bad;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_vector();
    test_scalar();
    test_flush();
    test_same_cycle();
    test_clear_full();
    test_reset_mid_fill();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

endmodule
